sampler_mem_arbiter: RTL

Round-robin arbiter that shares the TestSampler's single-port sample memory between two burst requesters (the AXI4 slave front end and the capture engine). It grants one requester at a time and holds the grant for a whole INCR burst of up to 8 beats of 32-bit words. It drives the memory's enable, write, address and data lines and routes read data back to the granted requester. It sits between the requesters and the sample RAM, inside the TestSampler IP.

---
 rtl/sampler_mem_arbiter_if.sv | 37 +++
 rtl/sampler_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sampler_mem_arbiter_if.sv
// Requester-side and memory-side bundles for sampler_mem_arbiter.
// master drives the command/memory request; slave answers it.
interface arb_req_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wdata;
  logic              beat;
  logic              rvalid;
  logic              rlast;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, len, wdata,
                  input  ready, beat, rvalid, rlast, rdata);
  modport slave  (input  valid, we, addr, len, wdata,
                  output ready, beat, rvalid, rlast, rdata);
endinterface

interface arb_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/sampler_mem_arbiter.sv
// Two-requester burst arbiter for the sampler's single-port sample RAM.
// Define SAMPLER_ARB_FIXED_PRIO_EN for fixed priority (req0 wins) instead of round robin.
//
// state   | meaning
// IDLE    | waiting for a request; accept pulses ready combinationally
// BURST   | one memory beat per cycle, beat_q = 0..len_q
// DONE    | last read beat returns; bus turnaround
module sampler_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic      ACLK,
  input  logic      ARESET,
  arb_req_if.slave  req0,
  arb_req_if.slave  req1,
  arb_mem_if.master mem
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              rd_last_q, rd_last_d;
  logic              accept, win, in_burst, rv0, rv1;

`ifdef SAMPLER_ARB_FIXED_PRIO_EN
  assign win = ~req0.valid;
`else
  logic ptr_q, ptr_d;

  // ptr_q names the requester that wins the next tie
  assign win   = (req0.valid & req1.valid) ? ptr_q : req1.valid;
  assign ptr_d = accept ? ~win : ptr_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  // ready must read 0 while reset is asserted even if a valid is pending
  assign accept = (state_q == S_IDLE) & (req0.valid | req1.valid) & ~ARESET;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BURST;
          gnt_d   = win;
          we_d    = win ? req1.we   : req0.we;
          addr_d  = win ? req1.addr : req0.addr;
          len_d   = win ? req1.len  : req0.len;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_burst  = (state_q == S_BURST);
  assign rd_vld_d  = in_burst & ~we_q;
  assign rd_gnt_d  = gnt_q;
  assign rd_last_d = (beat_q == len_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      rd_vld_q  <= rd_vld_d;
      rd_gnt_q  <= rd_gnt_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign rv0 = rd_vld_q & ~rd_gnt_q;
  assign rv1 = rd_vld_q &  rd_gnt_q;

  always_comb begin
    mem.en      = in_burst;
    mem.we      = in_burst & we_q;
    mem.addr    = in_burst ? addr_q + ADDR_W'(beat_q) : '0;
    mem.wdata   = in_burst ? (gnt_q ? req1.wdata : req0.wdata) : '0;
    req0.ready  = accept & ~win;
    req1.ready  = accept &  win;
    req0.beat   = in_burst & ~gnt_q;
    req1.beat   = in_burst &  gnt_q;
    req0.rvalid = rv0;
    req1.rvalid = rv1;
    req0.rlast  = rv0 & rd_last_q;
    req1.rlast  = rv1 & rd_last_q;
    req0.rdata  = rv0 ? mem.rdata : '0;
    req1.rdata  = rv1 ? mem.rdata : '0;
  end

endmodule
